lbp_hist: RTL
=============

Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage.
- Snoops the LBP write port (`lbp_write`/`lbp_addr`/`lbp_data`) alongside the LBP result memory. Each interior-pixel code is classified into a rotation-invariant uniform (riu2) bin, and a 10-bin histogram is accumulated.
- When LBP asserts `finish`, the block streams the histogram out over a valid/ready interface to the feature/classifier stage.

Parameters:
- `IMG_W`, 8: image width/height in pixels; the image is square, IMG_W×IMG_W.
- `EXP_PIX`, 36: expected number of interior LBP writes per frame, (IMG_W-2)².
- `CNT_W`, 6: width of each bin counter and of `hist_count`; must satisfy 2^CNT_W-1 ≥ EXP_PIX.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `lbp_write`, input, 1: LBP result write strobe; one sample per high cycle.
- `lbp_addr`, input, 6: LBP result address, row*IMG_W+col.
- `lbp_data`, input, 8: LBP code.
- `finish`, input, 1: LBP frame-complete level from the LBP stage.
- `hist_clr`, input, 1: pulse; clears the histogram and rearms for a new frame.
- `hist_valid`, output, 1: histogram bin on the output bus is valid.
- `hist_ready`, input, 1: downstream accepts the current bin.
- `hist_bin`, output, 4: bin index, 0..9.
- `hist_count`, output, CNT_W: count for `hist_bin`.
- `hist_last`, output, 1: high with bin 9.
- `done`, output, 1: high after bin 9 has been accepted.
- `err`, output, 1: sticky protocol-error flag.

Behaviour:
- Reset, synchronous:
  - state=CLEAR; all bins, sample_cnt and err cleared.
  - Outputs: `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `hist_last`=0, `done`=0, `err`=0.
  - Reset applied mid-DUMP aborts the stream immediately; `hist_valid` is low in the next cycle.
- riu2 classification, combinational from `lbp_data`:
  - t = number of bit changes around the circular sequence d[0]..d[7],d[0].
  - If t≤2, bin = popcount(d), giving 0..8; else bin = 9.
- Address filter: accept only row∈[1,IMG_W-2] and col∈[1,IMG_W-2].
- States:
  - CLEAR (1 cycle): zero bins, sample_cnt and err → ACCUM.
  - ACCUM:
    - On `lbp_write` with an accepted address: bin[k]++ (saturating at 2^CNT_W-1) and sample_cnt++ (saturating).
    - On `lbp_write` with a rejected address: ignored, err←1.
    - When `finish`=1: → DUMP. If sample_cnt (including any same-cycle write) ≠ EXP_PIX, err←1.
    - A write coinciding with `finish` is counted before the transition.
  - DUMP:
    - `hist_valid`=1 with `hist_bin`=i and `hist_count`=bin[i], starting at i=0.
    - Advance i only on `hist_valid`&&`hist_ready`.
    - `hist_valid`, `hist_bin` and `hist_count` stay stable while `hist_ready`=0.
    - `hist_last`=1 when i=9; the handshake at i=9 → DONE.
    - Bins are read from registers, so there is no added latency. Bin 0 is presented in the first DUMP cycle, 1 cycle after `finish` is seen.
  - DONE: `done`=1, `hist_valid`=0; holds until `hist_clr` or `reset`.
- `lbp_write` in DUMP or DONE: ignored, err←1.
- `hist_clr` in any state: → CLEAR next cycle.
  - Takes priority over a same-cycle write or `finish`.
  - Clears err.
- `finish` is a level and may stay high after LBP completes. It is ignored outside ACCUM, and ACCUM is entered only from CLEAR.
- Throughput: one sample per cycle; back-to-back writes are supported.

Test Plan:
- Reset, then 36 interior writes of 0x00 at addrs 9..14,17..22,...,49..54, then `finish`=1, `hist_ready`=1 → 10 consecutive beats: bin0=36, bins1..9=0; `hist_last` on beat 10; `done`=1 next cycle; err=0.
- Classification: one write each of 0x00, 0xFF, 0x0F, 0x81, 0x55, 0x36, with the remaining 30 writes 0x00 → bin0=31, bin8=1, bin4=1, bin2=1, bin9=2; err=0.
- Backpressure: during DUMP, toggle `hist_ready` 0,0,1 per beat → each bin held stable for 3 cycles; 10 bins in order; no bin skipped or duplicated.
- Error cases:
  - A write at addr 0 plus 36 valid writes → ignored, err=1, bin totals still 36.
  - Only 35 writes, then `finish` → DUMP proceeds, err=1.
- Write coinciding with the `finish` cycle is counted: 35 writes, then the 36th write in the same cycle as `finish` → err=0, total 36.
- `hist_clr` during DUMP at bin 4 → `hist_valid`=0 next cycle; CLEAR, then ACCUM; a new 36-write frame produces a fresh histogram.
- Synchronous `reset` mid-ACCUM → all outputs 0 next cycle; histogram empty.

Source files
------------

// File: rtl/lbp_hist.sv
// lbp_hist: snoops LBP result writes, builds a 10-bin rotation-invariant
// uniform (riu2) histogram over interior pixels, and streams it out on finish.
module lbp_hist #(
    parameter int unsigned IMG_W   = 8,
    parameter int unsigned EXP_PIX = 36,
    parameter int unsigned CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_write,
    input  logic [5:0]       lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    input  logic             hist_clr,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [3:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_last,
    output logic             done,
    output logic             err
);

    localparam int unsigned NBIN   = 10;
    localparam int unsigned BIN_W  = 4;
    localparam int unsigned ADDR_W = 6;

    typedef enum logic [1:0] {CLEAR, ACCUM, DUMP, DONE} state_t;

    state_t                           state_q, state_n;
    logic [NBIN-1:0][CNT_W-1:0]       bins_q, bins_n;
    logic [CNT_W-1:0]                 cnt_q, cnt_n;
    logic [BIN_W-1:0]                 idx_q, idx_n;
    logic                             err_n;
    logic                             valid_n, last_n, done_n;
    logic [BIN_W-1:0]                 bin_n;
    logic [CNT_W-1:0]                 count_n;
    logic [ADDR_W-1:0]                row, col;
    logic                             addr_ok;
    logic [BIN_W-1:0]                 code_bin;

    // riu2 bin: popcount for codes with at most two circular transitions, else 9
    function automatic logic [BIN_W-1:0] riu2_bin(input logic [7:0] d);
        logic [7:0]       rot;
        logic [BIN_W-1:0] t;
        logic [BIN_W-1:0] pc;
        rot = {d[0], d[7:1]};
        t   = '0;
        pc  = '0;
        for (int i = 0; i < 8; i++) begin
            t  = t + BIN_W'(d[i] ^ rot[i]);
            pc = pc + BIN_W'(d[i]);
        end
        return (t <= BIN_W'(2)) ? pc : BIN_W'(NBIN - 1);
    endfunction

    // Address decode and code classification for the current write
    always_comb begin
        row      = lbp_addr / ADDR_W'(IMG_W);
        col      = lbp_addr % ADDR_W'(IMG_W);
        addr_ok  = (row >= ADDR_W'(1)) && (row <= ADDR_W'(IMG_W - 2)) &&
                   (col >= ADDR_W'(1)) && (col <= ADDR_W'(IMG_W - 2));
        code_bin = riu2_bin(lbp_data);
    end

    // Next-state, histogram update and next output values
    always_comb begin
        state_n = state_q;
        bins_n  = bins_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        err_n   = err;

        if (hist_clr) begin
            state_n = CLEAR;
            err_n   = 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    bins_n  = '0;
                    cnt_n   = '0;
                    idx_n   = '0;
                    err_n   = 1'b0;
                    state_n = ACCUM;
                end
                ACCUM: begin
                    if (lbp_write) begin
                        if (addr_ok) begin
                            if (bins_n[code_bin] != '1)
                                bins_n[code_bin] = bins_n[code_bin] + CNT_W'(1);
                            if (cnt_n != '1)
                                cnt_n = cnt_n + CNT_W'(1);
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    // same-cycle write is already folded into cnt_n
                    if (finish) begin
                        state_n = DUMP;
                        idx_n   = '0;
                        if (cnt_n != CNT_W'(EXP_PIX))
                            err_n = 1'b1;
                    end
                end
                DUMP: begin
                    if (lbp_write)
                        err_n = 1'b1;
                    if (hist_ready) begin
                        if (idx_q == BIN_W'(NBIN - 1))
                            state_n = DONE;
                        else
                            idx_n = idx_q + BIN_W'(1);
                    end
                end
                DONE: begin
                    if (lbp_write)
                        err_n = 1'b1;
                end
                default: state_n = CLEAR;
            endcase
        end

        valid_n = (state_n == DUMP);
        bin_n   = valid_n ? idx_n : '0;
        count_n = valid_n ? bins_n[idx_n] : '0;
        last_n  = valid_n && (idx_n == BIN_W'(NBIN - 1));
        done_n  = (state_n == DONE);
    end

    // State, histogram and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            bins_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            err        <= 1'b0;
            hist_valid <= 1'b0;
            hist_bin   <= '0;
            hist_count <= '0;
            hist_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_n;
            bins_q     <= bins_n;
            cnt_q      <= cnt_n;
            idx_q      <= idx_n;
            err        <= err_n;
            hist_valid <= valid_n;
            hist_bin   <= bin_n;
            hist_count <= count_n;
            hist_last  <= last_n;
            done       <= done_n;
        end
    end

endmodule
